// File: rtl/hamming_secded_pkg.sv
// hamming_secded_pkg: shared sizing, codeword position helpers and decode classes for the SECDED pipe
// Contents: calc_par_w (Hamming parity bits for a data width), is_pow2, data_pos (data index -> codeword
// position), par_mask (data bits covered by one Hamming parity bit), dec_t (decode classification).
package hamming_secded_pkg;

    typedef enum logic [1:0] {
        DEC_CLEAN = 2'd0,
        DEC_1BIT  = 2'd1,
        DEC_PAR   = 2'd2,
        DEC_2BIT  = 2'd3
    } dec_t;

    function automatic int calc_par_w(input int data_w);
        int r = 1;
        while ((1 << r) < data_w + r + 1) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int p);
        return p > 0 && (p & (p - 1)) == 0;
    endfunction

    // Data bits fill the non-power-of-two positions LSB-first, starting at position 3.
    function automatic int data_pos(input int idx);
        int cnt = 0;
        int pos = 0;
        for (int p = 3; p < 128; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [63:0] par_mask(input int j);
        logic [63:0] m = '0;
        for (int i = 0; i < 64; i++)
            if ((data_pos(i) & (1 << j)) != 0) m = m | (64'(1) << i);
        return m;
    endfunction

endpackage

// File: rtl/hamming_secded_enc.sv
// hamming_secded_enc: combinational DATA_W -> CODE_W extended Hamming encoder
// Ports: i_data (data word), o_code (codeword; bit 0 overall parity, Hamming parity at powers of two).
module hamming_secded_enc
    import hamming_secded_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]                  i_data,
    output logic [DATA_W+calc_par_w(DATA_W):0] o_code
);

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic [CODE_W-1:1] w_hb;

    for (genvar i = 0; i < DATA_W; i++) begin : g_d
        assign w_hb[data_pos(i)] = i_data[i];
    end

    for (genvar j = 0; j < PAR_W; j++) begin : g_p
        assign w_hb[1 << j] = ^(i_data & DATA_W'(par_mask(j)));
    end

    assign o_code = {w_hb, ^w_hb};

endmodule

// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: two-stage SECDED encode / noise-inject / decode channel with valid-ready flow control
// Ports: i_clk, i_rst_n (async active-low); input stream i_valid/o_ready/i_data/i_noise;
// output stream o_valid/i_ready/o_data with o_1bit_error, o_2bit_error, o_parity_error, o_syndrome;
// i_cnt_clr, o_cnt_1bit, o_cnt_2bit saturating error statistics, built only when SECDED_ERR_CNT_EN is defined
// (otherwise the counters read 0 and i_cnt_clr is ignored).
module hamming_secded_pipe
    import hamming_secded_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [DATA_W-1:0]                 i_data,
    input  logic [DATA_W+calc_par_w(DATA_W):0] i_noise,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [DATA_W-1:0]                 o_data,
    output logic                              o_1bit_error,
    output logic                              o_2bit_error,
    output logic                              o_parity_error,
    output logic [calc_par_w(DATA_W)-1:0]     o_syndrome,
    input  logic                              i_cnt_clr,
    output logic [CNT_W-1:0]                  o_cnt_1bit,
    output logic [CNT_W-1:0]                  o_cnt_2bit
);

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              r_s1_valid, r_valid;
    logic [CODE_W-1:0] r_s1_code;
    logic [DATA_W-1:0] r_data;
    logic [PAR_W-1:0]  r_syn;
    dec_t              r_cls;

    logic              w_s1_en, w_s2_en, w_par;
    logic [CODE_W-1:0] w_enc, w_re, w_flip, w_fix_code;
    logic [DATA_W-1:0] w_raw, w_fix;
    logic [PAR_W-1:0]  w_syn;
    dec_t              w_cls;
    logic              w_unused_s2;

    assign w_s2_en = !r_valid || i_ready;
    assign w_s1_en = !r_s1_valid || w_s2_en;
    assign o_ready = w_s1_en;

    hamming_secded_enc #(.DATA_W(DATA_W)) u_enc_s1 (.i_data(i_data), .o_code(w_enc));

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= i_valid;
            if (i_valid) r_s1_code <= w_enc ^ i_noise;
        end

    // Syndrome = received Hamming parity bits XOR parity re-encoded from the received data.
    for (genvar i = 0; i < DATA_W; i++) begin : g_x
        assign w_raw[i] = r_s1_code[data_pos(i)];
        assign w_fix[i] = w_fix_code[data_pos(i)];
    end

    hamming_secded_enc #(.DATA_W(DATA_W)) u_enc_s2 (.i_data(w_raw), .o_code(w_re));

    for (genvar j = 0; j < PAR_W; j++) begin : g_s
        assign w_syn[j] = r_s1_code[1 << j] ^ w_re[1 << j];
    end

    assign w_par = ^r_s1_code;
    assign w_cls = !w_par ? (w_syn == '0 ? DEC_CLEAN : DEC_2BIT)
                 : w_syn == '0 ? DEC_PAR
                 : int'(w_syn) < CODE_W ? DEC_1BIT : DEC_2BIT;
    assign w_flip      = w_cls == DEC_1BIT ? CODE_W'(1) << w_syn : '0;
    assign w_fix_code  = r_s1_code ^ w_flip;
    assign w_unused_s2 = ^{w_re, w_fix_code};

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_syn   <= '0;
            r_cls   <= DEC_CLEAN;
        end else if (w_s2_en) begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data <= w_fix;
                r_syn  <= w_syn;
                r_cls  <= w_cls;
            end
        end

    assign o_valid        = r_valid;
    assign o_data         = r_data;
    assign o_syndrome     = r_syn;
    assign o_1bit_error   = r_cls == DEC_1BIT || r_cls == DEC_PAR;
    assign o_parity_error = r_cls == DEC_PAR;
    assign o_2bit_error   = r_cls == DEC_2BIT;

`ifdef SECDED_ERR_CNT_EN
    logic [CNT_W-1:0] r_cnt_1bit, r_cnt_2bit;
    logic             w_hs;

    assign w_hs = r_valid && i_ready;

    // Clear wins over a coincident increment; increments stop at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_cnt_1bit <= '0;
            r_cnt_2bit <= '0;
        end else begin
            r_cnt_1bit <= i_cnt_clr ? '0 : r_cnt_1bit + CNT_W'(w_hs && o_1bit_error && r_cnt_1bit != '1);
            r_cnt_2bit <= i_cnt_clr ? '0 : r_cnt_2bit + CNT_W'(w_hs && o_2bit_error && r_cnt_2bit != '1);
        end

    assign o_cnt_1bit = r_cnt_1bit;
    assign o_cnt_2bit = r_cnt_2bit;
`else
    logic w_unused_cnt;

    assign w_unused_cnt = i_cnt_clr;
    assign o_cnt_1bit   = '0;
    assign o_cnt_2bit   = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb_hamming_secded_pipe: scoreboard bench for hamming_secded_pipe (DATA_W=8, CNT_W=2)
module tb_hamming_secded_pipe;

    logic        clk = 0, rst_n = 1, i_valid = 0, i_ready = 1, i_cnt_clr = 0;
    logic [7:0]  i_data = 0;
    logic [12:0] i_noise = 0;
    logic        o_ready, o_valid, o_1bit_error, o_2bit_error, o_parity_error;
    logic [7:0]  o_data;
    logic [3:0]  o_syndrome;
    logic [1:0]  o_cnt_1bit, o_cnt_2bit;

    typedef struct {
        logic [7:0] d;
        logic       e1, e2, ep;
        logic [3:0] s;
        bit         lat;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         total = 0, bad = 0, cyc = 0, stalls = 0, w;
    logic [7:0] held;

    hamming_secded_pipe #(.DATA_W(8), .CNT_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_noise(i_noise), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_1bit_error(o_1bit_error), .o_2bit_error(o_2bit_error),
        .o_parity_error(o_parity_error), .o_syndrome(o_syndrome), .i_cnt_clr(i_cnt_clr),
        .o_cnt_1bit(o_cnt_1bit), .o_cnt_2bit(o_cnt_2bit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] ce(input int v);
`ifdef SECDED_ERR_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [12:0] n, input logic [7:0] ed,
                        input logic e1, input logic e2, input logic ep, input logic [3:0] s, input bit lat);
        int k = 0;
        i_valid = 1;
        i_data  = d;
        i_noise = n;
        #1;
        while (!o_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        stalls += k;
        if (!o_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout data=%0h got=ready_low want=ready_high", d);
        end else q.push_back('{ed, e1, e2, ep, s, lat, cyc});
        @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        i_valid = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d_pending want=0", q.size());
            q.delete();
        end
        @(negedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && o_valid && i_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word got=%0h want=none", o_data);
            end else begin
                e = q.pop_front();
                chk("word{data,1b,2b,par,syn}",
                    {o_data, o_1bit_error, o_2bit_error, o_parity_error, o_syndrome},
                    {e.d, e.e1, e.e2, e.ep, e.s});
                if (e.lat) chk("latency", cyc - e.cyc, 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 0;
        #1;
        chk("rst_async_valid", o_valid, 0);
        chk("rst_async_ready", o_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_flags", {o_1bit_error, o_2bit_error, o_parity_error}, 0);
        chk("rst_syn", o_syndrome, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_cnt", {o_cnt_1bit, o_cnt_2bit}, 0);

        @(negedge clk);
        stalls = 0;
        for (int v = 0; v < 256; v++) send(8'(v), 13'h0, 8'(v), 0, 0, 0, 4'd0, 1);
        drain();
        chk("t1_stalls", stalls, 0);
        chk("t1_cnt", {o_cnt_1bit, o_cnt_2bit}, 0);

        @(negedge clk);
        for (int k = 1; k < 13; k++) send(8'hA5, 13'(1) << k, 8'hA5, 1, 0, 0, 4'(k), 1);
        send(8'hA5, 13'h1, 8'hA5, 1, 0, 1, 4'd0, 1);
        drain();
        chk("t2_cnt1_sat", o_cnt_1bit, ce(3));
        chk("t2_cnt2", o_cnt_2bit, 0);

        i_cnt_clr = 1;
        @(negedge clk);
        i_cnt_clr = 0;
        #1;
        chk("t3_clr", {o_cnt_1bit, o_cnt_2bit}, 0);
        @(negedge clk);
        send(8'h3C, 13'h012, 8'h3C, 0, 1, 0, 4'd5, 1);
        drain();
        chk("t3_cnt2_inc", o_cnt_2bit, ce(1));
        chk("t3_cnt1", o_cnt_1bit, 0);
        @(negedge clk);
        send(8'h3C, 13'h028, 8'h3F, 0, 1, 0, 4'd6, 1);
        send(8'hA5, 13'h1006, 8'h25, 0, 1, 0, 4'd15, 1);
        drain();
        chk("t3_cnt2_sat", o_cnt_2bit, ce(3));

        @(negedge clk);
        i_ready = 0;
        fork
            begin
                send(8'h11, 13'h0, 8'h11, 0, 0, 0, 4'd0, 0);
                send(8'h22, 13'h0, 8'h22, 0, 0, 0, 4'd0, 0);
                send(8'h33, 13'h0, 8'h33, 0, 0, 0, 4'd0, 0);
                send(8'h44, 13'h008, 8'h44, 1, 0, 0, 4'd3, 0);
                i_valid = 0;
            end
            begin
                repeat (2) @(negedge clk);
                #1;
                chk("t4_ready_low", o_ready, 0);
                chk("t4_valid_held", o_valid, 1);
                chk("t4_head", o_data, 8'h11);
                held = o_data;
                repeat (2) begin
                    @(negedge clk);
                    #1;
                    chk("t4_stable", o_data, held);
                    chk("t4_still_full", o_ready, 0);
                end
                @(negedge clk);
                i_ready = 1;
            end
        join
        drain();

        i_cnt_clr = 1;
        @(negedge clk);
        i_cnt_clr = 0;
        for (int k = 0; k < 2; k++) send(8'h5A, 13'(1) << (k + 3), 8'h5A, 1, 0, 0, 4'(k + 3), 1);
        drain();
        chk("t5_cnt1_two", o_cnt_1bit, ce(2));
        @(negedge clk);
        for (int k = 5; k < 8; k++) send(8'h5A, 13'(1) << k, 8'h5A, 1, 0, 0, 4'(k), 1);
        drain();
        chk("t5_cnt1_sat", o_cnt_1bit, ce(3));
        @(negedge clk);
        i_ready = 0;
        send(8'h5A, 13'h400, 8'h5A, 1, 0, 0, 4'd10, 0);
        i_valid = 0;
        w = 0;
        while (!o_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("t5_word_ready", o_valid, 1);
        chk("t5_sat_hold", o_cnt_1bit, ce(3));
        i_cnt_clr = 1;
        i_ready = 1;
        @(negedge clk);
        i_cnt_clr = 0;
        #1;
        chk("t5_clr_wins", o_cnt_1bit, 0);
        drain();

        @(negedge clk);
        i_ready = 0;
        send(8'h77, 13'h0, 8'h77, 0, 0, 0, 4'd0, 0);
        send(8'h88, 13'h0, 8'h88, 0, 0, 0, 4'd0, 0);
        i_valid = 0;
        #3 rst_n = 0;
        #1;
        chk("t6_valid_drop", o_valid, 0);
        chk("t6_data_zero", o_data, 0);
        chk("t6_ready", o_ready, 1);
        chk("t6_cnt_zero", {o_cnt_1bit, o_cnt_2bit}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1;
        i_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_ghost", o_valid, 0);
        chk("t6_ready_after", o_ready, 1);
        @(negedge clk);
        send(8'h99, 13'h0, 8'h99, 0, 0, 0, 4'd0, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_secded_pipe.md
Name: hamming_secded_pipe

Overview:
Parametrised, pipelined Hamming SECDED encode/inject/decode channel, the successor to the 4-bit combinational SECDED block. DATA_W data bits are encoded into a CODE_W-bit extended Hamming codeword, XOR-corrupted by a per-word noise mask, then decoded and corrected. A valid/ready stream interface and optional saturating error statistics let it sit in the memory/link datapath and in self-test benches.

Parameters:
DATA_W, 8, data bits per word (legal 4..57)
PAR_W, derived (DATA_W=8 -> 4), smallest r with 2^r >= DATA_W+r+1; localparam, not overridable
CODE_W, derived (DATA_W=8 -> 13), DATA_W+PAR_W+1; localparam
CNT_W, 16, error-counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  input word valid
o_ready  out  1  block can accept input
i_data  in  DATA_W  data to protect
i_noise  in  CODE_W  error mask XORed onto the codeword; sampled with i_data
o_valid  out  1  output word valid
i_ready  in  1  downstream accepts output
o_data  out  DATA_W  corrected data
o_1bit_error  out  1  single error corrected (data bit or Hamming parity bit)
o_2bit_error  out  1  double error detected, data uncorrected
o_parity_error  out  1  only the overall parity bit was in error
o_syndrome  out  PAR_W  raw syndrome of the output word
i_cnt_clr  in  1  synchronous clear of the error counters
o_cnt_1bit  out  CNT_W  saturating count of corrected words
o_cnt_2bit  out  CNT_W  saturating count of double-error words

Behaviour:
- Codeword layout: bit 0 is the overall parity (XOR of bits 1..CODE_W-1). Bits 1..CODE_W-1 are standard Hamming positions: parity at powers of two, data LSB-first at the remaining positions.
- Stage 1 (S1): on input handshake (i_valid && o_ready), register encode(i_data) ^ i_noise and set s1_valid.
- Stage 2 (S2): on S1 advance, compute syndrome s and overall parity p, correct, and register the outputs and s2_valid.
- Latency: exactly 2 cycles from input handshake to o_valid when unstalled. Throughput is 1 word/cycle.
- Flow control:
  - s2_en = !s2_valid || i_ready
  - s1_en = !s1_valid || s2_en
  - o_ready = s1_en, a combinational path from i_ready
  - Stalled stages hold their contents. Outputs stay stable while o_valid && !i_ready.
- Decode classification:
  - s=0, p=0: clean, all flags 0.
  - p=1, s=0: o_parity_error=1, o_1bit_error=1, data unchanged.
  - p=1, 0<s<CODE_W: flip bit s, o_1bit_error=1.
  - p=1, s>=CODE_W: treat as uncorrectable, o_2bit_error=1.
  - s!=0, p=0: o_2bit_error=1, o_data = raw extracted data.
  - Flags are mutually exclusive, except that parity_error implies 1bit_error.
  - Three or more errors are undefined (may miscorrect); no requirement.
- Counters increment on output handshake (o_valid && i_ready) per flag, saturate at all-ones, and do not wrap. If i_cnt_clr coincides with an increment, the counter becomes 0.
- Reset: s1_valid=0, s2_valid=0, o_valid=0, o_data=0, all flags 0, o_syndrome=0, counters 0, o_ready=1 after reset. Reset asserted mid-stream drops in-flight words.

Optional Feature:
SECDED_ERR_CNT_EN.
- Defined: the counters and i_cnt_clr operate as described above.
- Undefined: counter logic is not built, o_cnt_1bit and o_cnt_2bit are tied to 0, i_cnt_clr is ignored. Port list is unchanged.

Decomposition:
- Shared package hamming_secded_pkg:
  - function computing PAR_W from DATA_W
  - codeword position helpers (is_pow2, data-index-to-position map)
  - flag encoding constants
- One sub-module: hamming_secded_enc, a combinational DATA_W -> CODE_W encoder. It is instanced in S1 and reused in S2 for syndrome recompute.

Test Plan (DATA_W=8, CODE_W=13):
1. No error: all 256 i_data values, i_noise=0, i_ready=1 back-to-back -> o_data equals input 2 cycles later, all flags 0, one word per cycle.
2. Single error: i_data=8'hA5 with i_noise=1<<k for k=1..12 -> o_data=8'hA5, o_1bit_error=1, o_syndrome=k. Then k=0 -> o_parity_error=1, o_1bit_error=1, o_syndrome=0.
3. Double error: i_data=8'h3C, i_noise=13'b0_0000_0001_0010 -> o_2bit_error=1, o_1bit_error=0, o_cnt_2bit increments by 1.
4. Backpressure: 4 words sent, i_ready held low 5 cycles -> o_ready=0 after the 2 pipeline slots fill, o_data stable, no loss or duplication, order preserved on release.
5. Counters: CNT_W=2, 5 single-error words -> o_cnt_1bit saturates at 3. i_cnt_clr together with a 6th error word -> 0.
6. Reset mid-flight: assert i_rst_n=0 with both stages valid -> o_valid=0 immediately (asynchronous), counters 0, o_ready=1 after release.
